// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//
// Sums unsigned products from an array multiplier into a 16-bit accumulator.
// A read request takes a snapshot of the accumulator and streams it out
// byte-serially: low byte first, then the high byte.
//
// Optional feature (compile-time macro):
//   PACC_SATURATE_EN  defined   -> overflowing sums clamp to all-ones and set
//                                  the sticky 'sat' flag.
//                     undefined -> the accumulator wraps and 'sat' stays 0.
//
// Ports:
//   clk         in   single clock, rising-edge
//   rst         in   asynchronous active-high reset
//   ena         in   block enable; low freezes all state
//   prod_valid  in   product present on prod_data
//   prod_ready  out  block can accept a product (IDLE, enabled, not in reset)
//   prod_data   in   unsigned product, PROD_W bits
//   acc_clr     in   clear accumulator, count and sat (snapshot untouched)
//   rd_req      in   start a byte-serial readout (honoured only in IDLE)
//   out_valid   out  out_byte holds a valid byte
//   out_ready   in   consumer accepts out_byte
//   out_byte    out  readout byte
//   out_last    out  marks the final (high) byte
//   busy        out  FSM is not IDLE
//   count       out  products accumulated, saturating at 15
//   sat         out  sticky overflow flag
//
// Handshakes: a beat moves on a rising clk edge where valid and ready are
// both high. out_byte/out_last are driven only from registered state, so
// they hold stable while out_ready is low.
// ---------------------------------------------------------------------------
module product_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod_data,
    input  logic              acc_clr,
    input  logic              rd_req,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              out_last,
    output logic              busy,
    output logic [3:0]        count,
    output logic              sat
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   snap_q, snap_d;
    logic [3:0]         count_q, count_d;
    logic               sat_q, sat_d;

    logic               xfer;
    logic [ACC_W-1:0]   base_acc;
    logic [3:0]         base_cnt;
    logic               base_sat;
`ifdef PACC_SATURATE_EN
    logic [ACC_W:0]     sum;
`endif

    // rst is folded in so no product is offered while reset is asserted.
    assign prod_ready = ena && !rst && (state_q == IDLE);
    assign xfer       = prod_valid && prod_ready;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        snap_d   = snap_q;
        count_d  = count_q;
        sat_d    = sat_q;
        base_acc = acc_q;
        base_cnt = count_q;
        base_sat = sat_q;
`ifdef PACC_SATURATE_EN
        sum      = '0;
`endif
        if (ena) begin
            // Clear is applied first so a same-edge product lands on zero.
            base_acc = acc_clr ? '0   : acc_q;
            base_cnt = acc_clr ? 4'd0 : count_q;
            base_sat = acc_clr ? 1'b0 : sat_q;
            acc_d    = base_acc;
            count_d  = base_cnt;
            sat_d    = base_sat;

            if (xfer) begin
`ifdef PACC_SATURATE_EN
                sum = {1'b0, base_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_data};
                if (sum[ACC_W]) begin
                    acc_d = '1;
                    sat_d = 1'b1;
                end else begin
                    acc_d = sum[ACC_W-1:0];
                end
`else
                acc_d = base_acc + {{(ACC_W - PROD_W){1'b0}}, prod_data};
`endif
                if (base_cnt != 4'd15) begin
                    count_d = base_cnt + 4'd1;
                end
            end

            case (state_q)
                IDLE: begin
                    // Snapshot the post-update value so a product on the
                    // same edge is included in the readout.
                    if (rd_req) begin
                        snap_d  = acc_d;
                        state_d = SEND_LO;
                    end
                end
                SEND_LO: if (out_ready) state_d = SEND_HI;
                SEND_HI: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            snap_q  <= '0;
            count_q <= 4'd0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            snap_q  <= snap_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_byte  = 8'h00;
        out_last  = 1'b0;
        case (state_q)
            SEND_LO: begin
                out_valid = 1'b1;
                out_byte  = snap_q[7:0];
            end
            SEND_HI: begin
                out_valid = 1'b1;
                out_byte  = snap_q[ACC_W-1:8];
                out_last  = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign count = count_q;
    assign sat   = sat_q;

endmodule
